// File: rtl/param_decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct and scan modes.
// Scan mode rotates the active line every DIV cycles for multiplexed display select.
module param_decoder_scan #(
  parameter int SEL_W      = 3,
  parameter int DIV        = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    in_valid,
  output logic [(1<<SEL_W)-1:0]   dec_out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        scan_idx,
  output logic                    wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OUT_W-1:0] INACT    = {OUT_W{ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   dec_q, dec_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   scan_idx_q, scan_idx_d;
  logic               wrap_q, wrap_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
    return (OUT_W'(1) << idx) ^ INACT;
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = !en ? IDLE : (mode ? SCAN : DIRECT);
    dec_d      = dec_q;
    valid_d    = valid_q;
    scan_idx_d = scan_idx_q;
    wrap_d     = 1'b0;
    div_cnt_d  = '0;

    case (state_d)
      DIRECT: begin
        // sel_in is only looked at when qualified, so an undriven bus never reaches the outputs.
        if (in_valid) begin
          dec_d   = onehot(sel_in);
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      SCAN: begin
        valid_d = 1'b1;
        if (state_q != SCAN) begin
          dec_d = onehot(scan_idx_q);
        end else if (div_cnt_q == DIV_LAST) begin
          scan_idx_d = scan_idx_q + 1'b1;
          dec_d      = onehot(scan_idx_d);
          wrap_d     = (scan_idx_q == {SEL_W{1'b1}});
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        dec_d   = INACT;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: reset is sampled on the clock edge only, and all state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dec_q      <= INACT;
      valid_q    <= 1'b0;
      scan_idx_q <= '0;
      wrap_q     <= 1'b0;
      div_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dec_q      <= dec_d;
      valid_q    <= valid_d;
      scan_idx_q <= scan_idx_d;
      wrap_q     <= wrap_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  assign dec_out   = dec_q;
  assign out_valid = valid_q;
  assign scan_idx  = scan_idx_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_param_decoder_scan.sv
// Self-checking bench: two decoder instances (DIV=4 one-hot high, DIV=1 active low)
// driven in lockstep and compared against a cycle-level behavioural model.
module tb_param_decoder_scan;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, in_valid;
  logic [2:0] sel_in;

  logic [7:0] dec_o   [2];
  logic       valid_o [2];
  logic [2:0] idx_o   [2];
  logic       wrap_o  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_decoder_scan #(.SEL_W(3), .DIV(4), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .in_valid(in_valid),
    .dec_out(dec_o[0]), .out_valid(valid_o[0]), .scan_idx(idx_o[0]), .wrap(wrap_o[0])
  );

  param_decoder_scan #(.SEL_W(3), .DIV(1), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .in_valid(in_valid),
    .dec_out(dec_o[1]), .out_valid(valid_o[1]), .scan_idx(idx_o[1]), .wrap(wrap_o[1])
  );

  // Reference model: tracks how long the current scan index has been on show.
  int         m_div [2] = '{4, 1};
  bit         m_al  [2] = '{1'b0, 1'b1};
  logic [7:0] m_dec   [2];
  bit         m_valid [2];
  bit         m_wrap  [2];
  bit         m_scan  [2];
  int         m_idx   [2];
  int         m_held  [2];

  function automatic logic [7:0] oh(input int i, input bit al);
    logic [7:0] v;
    v = 8'(1) << i;
    return al ? ~v : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      if (!rst_n) begin
        m_dec[k] = m_al[k] ? 8'hFF : 8'h00;
        m_valid[k] = 1'b0; m_idx[k] = 0; m_scan[k] = 1'b0; m_held[k] = 0;
      end else if (!en) begin
        m_dec[k] = m_al[k] ? 8'hFF : 8'h00;
        m_valid[k] = 1'b0; m_scan[k] = 1'b0;
      end else if (!mode) begin
        m_scan[k] = 1'b0;
        if (in_valid) begin
          m_dec[k] = oh(int'(sel_in), m_al[k]);
          m_valid[k] = 1'b1;
        end else begin
          m_valid[k] = 1'b0;
        end
      end else if (!m_scan[k]) begin
        m_scan[k] = 1'b1; m_held[k] = 1; m_valid[k] = 1'b1;
        m_dec[k] = oh(m_idx[k], m_al[k]);
      end else if (m_held[k] < m_div[k]) begin
        m_held[k]++;
      end else begin
        m_idx[k]  = (m_idx[k] + 1) % 8;
        m_held[k] = 1;
        m_wrap[k] = (m_idx[k] == 0);
        m_dec[k]  = oh(m_idx[k], m_al[k]);
      end
    end
  endtask

  task automatic model_compare();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d dec_out", k), 32'(dec_o[k]), 32'(m_dec[k]));
      check($sformatf("dut%0d out_valid", k), 32'(valid_o[k]), 32'(m_valid[k]));
      check($sformatf("dut%0d scan_idx", k), 32'(idx_o[k]), 32'(m_idx[k]));
      check($sformatf("dut%0d wrap", k), 32'(wrap_o[k]), 32'(m_wrap[k]));
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic m, input logic [2:0] s, input logic v);
    rst_n = r; en = e; mode = m; sel_in = s; in_valid = v;
    @(posedge clk);
    model_step();
    #1;
    model_compare();
  endtask

  typedef struct {
    logic       en, mode, in_valid;
    logic [2:0] sel;
    logic [7:0] exp_dec_a;
    logic [7:0] exp_dec_b;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int guard;
    logic [7:0] one;

    one = 8'h01;
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{en: 1'b1, mode: 1'b0, in_valid: 1'b1, sel: 3'(i),
                  exp_dec_a: one << i, exp_dec_b: ~(one << i), exp_valid: 1'b1};
    end
    vecs[8] = '{en: 1'b1, mode: 1'b0, in_valid: 1'b0, sel: 3'd2,
                exp_dec_a: 8'h80, exp_dec_b: 8'h7F, exp_valid: 1'b0};

    // Reset held with en/mode asserting scan.
    tick(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    check("reset dec_out", 32'(dec_o[0]), 32'h00);
    check("reset out_valid", 32'(valid_o[0]), 32'h0);
    check("reset scan_idx", 32'(idx_o[0]), 32'h0);
    check("reset wrap", 32'(wrap_o[0]), 32'h0);
    check("reset dec_out active low", 32'(dec_o[1]), 32'hFF);

    // Direct sweep, then drop in_valid.
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].in_valid);
      check($sformatf("vec%0d dec_out", i), 32'(dec_o[0]), 32'(vecs[i].exp_dec_a));
      check($sformatf("vec%0d dec_out active low", i), 32'(dec_o[1]), 32'(vecs[i].exp_dec_b));
      check($sformatf("vec%0d out_valid", i), 32'(valid_o[0]), 32'(vecs[i].exp_valid));
    end

    // Scan for 40 cycles starting from index 0.
    for (int c = 0; c < 40; c++) begin
      tick(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
      check($sformatf("scan c%0d dec_out", c), 32'(dec_o[0]), 32'(one << ((c / 4) % 8)));
      check($sformatf("scan c%0d wrap", c), 32'(wrap_o[0]), 32'(c == 32));
    end

    // Pause at index 5 and resume.
    guard = 0;
    while (m_idx[0] != 5 && guard < 100) begin
      tick(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
      guard++;
    end
    check("reach idx5 within bound", 32'(guard < 100), 32'h1);
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
      check("pause dec_out", 32'(dec_o[0]), 32'h00);
      check("pause out_valid", 32'(valid_o[0]), 32'h0);
      check("pause scan_idx", 32'(idx_o[0]), 32'h5);
    end
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
      check("resume dec_out", 32'(dec_o[0]), 32'h20);
    end
    tick(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    check("resume advance dec_out", 32'(dec_o[0]), 32'h40);

    // Polarity on the active-low instance.
    tick(1'b1, 1'b1, 1'b0, 3'd3, 1'b1);
    check("active low sel3", 32'(dec_o[1]), 32'hF7);
    tick(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
    check("active low reset", 32'(dec_o[1]), 32'hFF);

    // Scan to index 2, switch to direct, resume scan, reset mid-scan.
    guard = 0;
    while (m_idx[0] != 2 && guard < 100) begin
      tick(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
      guard++;
    end
    check("reach idx2 within bound", 32'(guard < 100), 32'h1);
    tick(1'b1, 1'b1, 1'b0, 3'd6, 1'b1);
    check("switch direct dec_out", 32'(dec_o[0]), 32'h40);
    check("switch direct out_valid", 32'(valid_o[0]), 32'h1);
    tick(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    check("rescan dec_out", 32'(dec_o[0]), 32'h04);
    tick(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    check("midscan reset dec_out", 32'(dec_o[0]), 32'h00);
    check("midscan reset out_valid", 32'(valid_o[0]), 32'h0);
    check("midscan reset scan_idx", 32'(idx_o[0]), 32'h0);
    check("midscan reset wrap", 32'(wrap_o[0]), 32'h0);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic r, e, m, v;
      logic [2:0] s;
      r = ($urandom_range(0, 59) != 0);
      e = ($urandom_range(0, 9) != 0);
      m = ($urandom_range(0, 3) != 0);
      v = 1'($urandom_range(0, 1));
      s = v ? 3'($urandom_range(0, 7)) : 3'bxxx;
      tick(r, e, m, s, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
